// File: rtl/mar_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mar_pkg
// Purpose  : Shared types and constants for the memory-address-register unit:
//            controller state encoding, default geometry and the canonical
//            address-source indices used by the datapath.
// Ports    : none (package)
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
package mar_pkg;

    // Controller states: IDLE holds/increments the MAR, REQ presents it to memory.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } mar_state_e;

    // Default geometry.
    localparam int MAR_ADDR_W_DEF  = 8;
    localparam int MAR_NUM_SRC_DEF = 3;

    // Canonical address-source slots in the packed source bus.
    localparam int SRC_PC   = 0;
    localparam int SRC_DBUS = 1;
    localparam int SRC_IR   = 2;

endpackage : mar_pkg
`default_nettype wire

// File: rtl/mar_src_mux.sv
`default_nettype none
// ============================================================================
// Module   : mar_src_mux
// Purpose  : Combinational N-to-1 address-source selector. An out-of-range
//            select yields an all-zero address and raises 'invalid'.
// Ports    : src_addr [NUM_SRC*ADDR_W] in  packed sources, slot i at i*ADDR_W
//            sel      [SEL_W]          in  source index
//            addr_out [ADDR_W]         out selected address (0 if invalid)
//            invalid                   out sel >= NUM_SRC
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
module mar_src_mux #(
    parameter  int ADDR_W  = 8,
    parameter  int NUM_SRC = 3,
    localparam int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    input  logic [SEL_W-1:0]          sel,
    output logic [ADDR_W-1:0]         addr_out,
    output logic                      invalid
);

    logic [ADDR_W-1:0] src_arr [NUM_SRC];

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
            assign src_arr[i] = src_addr[i*ADDR_W +: ADDR_W];
        end
    endgenerate

    // Compare against every legal index instead of indexing the array with
    // sel directly, so an out-of-range select can never read past the array
    // and naturally falls through to zero.
    always_comb begin
        addr_out = '0;
        invalid  = ({1'b0, sel} >= (SEL_W+1)'(NUM_SRC));
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                addr_out = src_arr[i];
            end
        end
    end

endmodule : mar_src_mux
`default_nettype wire

// File: rtl/mar_addr_unit.sv
`default_nettype none
// ============================================================================
// Module   : mar_addr_unit
// Purpose  : Memory address register with source select, in-place increment,
//            valid/ready request tracking and optional post-increment on
//            request acceptance.
// Ports    : clk, rst_n (async, active-low)
//            src_addr [NUM_SRC*ADDR_W] in  packed address sources
//            src_sel  [SEL_W]          in  source index, sampled with load
//            load                      in  capture source, open request
//            inc                       in  MAR += 1, no request
//            auto_inc                  in  post-increment on accept (macro)
//            mem_req_valid             out request pending
//            mem_req_ready             in  memory accepts request
//            mar_addr [ADDR_W]         out current MAR (registered)
//            busy                      out same as mem_req_valid
//            sel_err                   out one-cycle pulse after bad src_sel
// Config   : MAR_AUTOINC_EN - when defined, auto_inc sampled at the accepting
//            edge post-increments the MAR; otherwise auto_inc is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module mar_addr_unit
    import mar_pkg::*;
#(
    parameter  int ADDR_W  = MAR_ADDR_W_DEF,
    parameter  int NUM_SRC = MAR_NUM_SRC_DEF,
    localparam int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    input  logic [SEL_W-1:0]          src_sel,
    input  logic                      load,
    input  logic                      inc,
    input  logic                      auto_inc,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [ADDR_W-1:0]         mar_addr,
    output logic                      busy,
    output logic                      sel_err
);

    mar_state_e        state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic              valid_q, valid_d;
    logic              sel_err_q, sel_err_d;

    logic [ADDR_W-1:0] mux_addr;
    logic              mux_invalid;
    logic              accept;
    logic              post_inc;

    mar_src_mux #(
        .ADDR_W  (ADDR_W),
        .NUM_SRC (NUM_SRC)
    ) u_src_mux (
        .src_addr (src_addr),
        .sel      (src_sel),
        .addr_out (mux_addr),
        .invalid  (mux_invalid)
    );

`ifdef MAR_AUTOINC_EN
    assign post_inc = auto_inc;
`else
    // auto_inc stays on the port list so the interface is build-independent.
    logic unused_auto_inc;
    assign unused_auto_inc = auto_inc;
    assign post_inc        = 1'b0;
`endif

    // ready is only meaningful while a request is outstanding.
    assign accept = valid_q && mem_req_ready;

    always_comb begin
        state_d   = state_q;
        mar_d     = mar_q;
        valid_d   = valid_q;
        sel_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    mar_d     = mux_addr;
                    sel_err_d = mux_invalid;
                    valid_d   = 1'b1;
                    state_d   = REQ;
                end else if (inc) begin
                    mar_d = mar_q + ADDR_W'(1);
                end
            end
            REQ: begin
                // Address is frozen until accepted; load/inc without an
                // accept are dropped.
                if (accept) begin
                    if (load) begin
                        // Back-to-back request: stay in REQ with no bubble.
                        mar_d     = mux_addr;
                        sel_err_d = mux_invalid;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                        if (post_inc) begin
                            mar_d = mar_q + ADDR_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mar_q     <= '0;
            valid_q   <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mar_q     <= mar_d;
            valid_q   <= valid_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign mar_addr      = mar_q;
    assign mem_req_valid = valid_q;
    assign busy          = valid_q;
    assign sel_err       = sel_err_q;

endmodule : mar_addr_unit
`default_nettype wire

// File: tb/tb_mar_addr_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mar_addr_unit
// Purpose  : Self-checking bench for mar_addr_unit (ADDR_W=8, NUM_SRC=3):
//            directed vector table, asynchronous-reset sequence and a
//            randomized run against a behavioural model.
// Config   : follows MAR_AUTOINC_EN for the post-increment expectation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mar_addr_unit;

    localparam int ADDR_W  = 8;
    localparam int NUM_SRC = 3;
`ifdef MAR_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_SRC*ADDR_W-1:0] src_addr = '0;
    logic [1:0]                src_sel = '0;
    logic                      load = 1'b0;
    logic                      inc = 1'b0;
    logic                      auto_inc = 1'b0;
    logic                      mem_req_valid;
    logic                      mem_req_ready = 1'b0;
    logic [ADDR_W-1:0]         mar_addr;
    logic                      busy;
    logic                      sel_err;

    int n_cmp = 0;
    int n_bad = 0;

    mar_addr_unit #(
        .ADDR_W  (ADDR_W),
        .NUM_SRC (NUM_SRC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .src_addr      (src_addr),
        .src_sel       (src_sel),
        .load          (load),
        .inc           (inc),
        .auto_inc      (auto_inc),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mar_addr      (mar_addr),
        .busy          (busy),
        .sel_err       (sel_err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0] m_addr;
    bit         m_pend;
    bit         m_err;

    task automatic model_edge();
        bit take_load;
        take_load = load && (!m_pend || mem_req_ready);
        if (take_load) begin
            m_addr = (src_sel < NUM_SRC) ? src_addr[src_sel*ADDR_W +: ADDR_W] : 8'h00;
            m_err  = (src_sel >= NUM_SRC);
            m_pend = 1'b1;
        end else begin
            m_err = 1'b0;
            if (m_pend) begin
                if (mem_req_ready) begin
                    m_pend = 1'b0;
                    if (AUTOINC && auto_inc) m_addr = m_addr + 8'd1;
                end
            end else if (inc) begin
                m_addr = m_addr + 8'd1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [7:0] ea, input bit ev, input bit ee);
        chk({tag, " mar_addr"}, 32'(mar_addr), 32'(ea));
        chk({tag, " valid"}, 32'(mem_req_valid), 32'(ev));
        chk({tag, " busy"}, 32'(busy), 32'(ev));
        chk({tag, " sel_err"}, 32'(sel_err), 32'(ee));
    endtask

    // Inputs are already set; advance one clock and settle.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load = 1'b0; inc = 1'b0; auto_inc = 1'b0; mem_req_ready = 1'b0; src_sel = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        m_addr = 8'h00; m_pend = 1'b0; m_err = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [23:0] src;
        logic [1:0]  sel;
        bit          ld;
        bit          in;
        bit          ai;
        bit          rdy;
        logic [7:0]  e_addr;
        bit          e_valid;
        bit          e_err;
    } vec_t;

    localparam logic [23:0] SRCS  = 24'h33_5A_10;  // IR=33, DBUS=5A, PC=10
    localparam logic [23:0] SRCFF = 24'h33_5A_FF;

    vec_t vecs[18];

    initial begin
        vecs[0]  = '{SRCS,  2'd1, 1, 0, 0, 0, 8'h5A, 1, 0}; // load DBUS
        vecs[1]  = '{SRCS,  2'd0, 0, 0, 0, 0, 8'h5A, 1, 0}; // held
        vecs[2]  = '{SRCS,  2'd0, 0, 0, 0, 0, 8'h5A, 1, 0}; // held
        vecs[3]  = '{SRCS,  2'd0, 0, 0, 0, 1, 8'h5A, 0, 0}; // accept
        vecs[4]  = '{SRCS,  2'd0, 1, 0, 0, 0, 8'h10, 1, 0}; // load PC
        vecs[5]  = '{SRCS,  2'd2, 1, 1, 0, 0, 8'h10, 1, 0}; // load+inc dropped
        vecs[6]  = '{SRCS,  2'd2, 1, 0, 0, 1, 8'h33, 1, 0}; // back-to-back
        vecs[7]  = '{SRCS,  2'd0, 0, 0, 1, 1, AUTOINC ? 8'h34 : 8'h33, 0, 0};
        vecs[8]  = '{SRCS,  2'd3, 1, 0, 0, 0, 8'h00, 1, 1}; // bad select
        vecs[9]  = '{SRCS,  2'd0, 0, 0, 0, 0, 8'h00, 1, 0}; // err one cycle
        vecs[10] = '{SRCS,  2'd0, 0, 0, 0, 1, 8'h00, 0, 0};
        vecs[11] = '{SRCFF, 2'd0, 1, 0, 0, 0, 8'hFF, 1, 0};
        vecs[12] = '{SRCFF, 2'd0, 0, 0, 0, 1, 8'hFF, 0, 0};
        vecs[13] = '{SRCFF, 2'd0, 0, 1, 0, 0, 8'h00, 0, 0}; // wrap
        vecs[14] = '{SRCFF, 2'd0, 0, 1, 0, 0, 8'h01, 0, 0};
        vecs[15] = '{SRCFF, 2'd0, 0, 0, 0, 1, 8'h01, 0, 0}; // ready in IDLE
        vecs[16] = '{SRCS,  2'd1, 1, 0, 0, 1, 8'h5A, 1, 0};
        vecs[17] = '{SRCS,  2'd0, 0, 0, 1, 1, AUTOINC ? 8'h5B : 8'h5A, 0, 0};
    end

    initial begin
        #1;
        do_reset();
        chk_outs("reset", 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 18; i++) begin
            src_addr      = vecs[i].src;
            src_sel       = vecs[i].sel;
            load          = vecs[i].ld;
            inc           = vecs[i].in;
            auto_inc      = vecs[i].ai;
            mem_req_ready = vecs[i].rdy;
            cycle();
            chk_outs($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_err);
        end
        idle_inputs();

        // Async reset mid-request: outputs clear before the next edge.
        src_addr = SRCS; src_sel = 2'd3; load = 1'b1;
        cycle();
        load = 1'b0;
        chk_outs("pre-areset", 8'h00, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("areset", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n  = 1'b1;
        m_addr = 8'h00; m_pend = 1'b0; m_err = 1'b0;
        @(posedge clk);
        #1;
        chk_outs("post-areset", 8'h00, 1'b0, 1'b0);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            src_addr      = 24'($urandom);
            src_sel       = 2'($urandom_range(0, 3));
            load          = ($urandom_range(0, 99) < 30);
            inc           = ($urandom_range(0, 99) < 30);
            auto_inc      = $urandom_range(0, 1) == 1;
            mem_req_ready = $urandom_range(0, 1) == 1;
            cycle();
            chk_outs("rand", m_addr, m_pend, m_err);
        end
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mar_addr_unit
`default_nettype wire

// File: doc/mar_addr_unit.md
# mar_addr_unit

Parametrised memory-address-register unit for the processor datapath: selects one of `NUM_SRC` address sources (PC, data bus, IR field, …), registers it as the current memory address, and presents it to the memory interface through a valid/ready request handshake. Generalises the combinational MAR source selector with parametrised width and source count, an in-place increment, request tracking and optional auto post-increment for sequential fetches. It sits between the address sources and the memory controller.

## Interface
Parameters:
- `ADDR_W`, 8, address width in bits (≥2)
- `NUM_SRC`, 3, number of address sources (≥2)
- `SEL_W`, `$clog2(NUM_SRC)`, select width (derived; not overridden)

Ports:
- `clk`  in  1  single clock, rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `src_addr`  in  `NUM_SRC*ADDR_W`  packed sources; source i at bits `[i*ADDR_W +: ADDR_W]`
- `src_sel`  in  `SEL_W`  source index, sampled with `load`
- `load`  in  1  capture selected source into MAR and open a request
- `inc`  in  1  MAR += 1 in place, no request opened
- `auto_inc`  in  1  post-increment MAR after each accepted request (macro-gated)
- `mem_req_valid`  out  1  MAR holds an address awaiting memory acceptance
- `mem_req_ready`  in  1  memory accepts the request
- `mar_addr`  out  `ADDR_W`  current MAR value, registered
- `busy`  out  1  equals `mem_req_valid`
- `sel_err`  out  1  one-cycle pulse: `load` with `src_sel ≥ NUM_SRC`

## Operation
- States: `IDLE`, `REQ`. Reset → `IDLE`, `mar_addr`=0, `mem_req_valid`=0, `sel_err`=0.
- `IDLE`: `load` → MAR ← `src_addr[src_sel]`, go `REQ`. Else `inc` → MAR ← MAR+1, stay. `load` has priority over `inc`.
- Invalid `src_sel` (≥ `NUM_SRC`): MAR ← 0, `sel_err` pulses next cycle, request still opens (address 0).
- `REQ`: `mar_addr` stable while `mem_req_valid`=1. `load` and `inc` ignored (dropped, not queued) unless handshake completes this cycle.
- Handshake completes at an edge where `mem_req_valid && mem_req_ready`:
  - if `load` same cycle: MAR ← new source, stay `REQ` (back-to-back, no bubble);
  - else if auto-inc active: MAR ← MAR+1, go `IDLE`;
  - else go `IDLE`, MAR unchanged.
- Arithmetic: increment is modulo 2^`ADDR_W`; all-ones wraps to 0 without flag.
- `mem_req_ready` while `IDLE`: ignored.

## Timing
- `load` at edge N → `mar_addr`, `mem_req_valid` valid after edge N (1-cycle latency).
- Accept at edge M → `mem_req_valid` low after M unless back-to-back load.
- `sel_err` high exactly one cycle after the offending edge.
- Async reset mid-request: `mem_req_valid` drops immediately; request abandoned.
- No combinational path from any input to any output.

## Configuration
- `MAR_AUTOINC_EN` defined: `auto_inc` sampled at the accepting edge; high → post-increment as above.
- Undefined: `auto_inc` ignored; MAR never changes on acceptance; port stays present for a fixed interface.

## Structure
- Package `mar_pkg`: state enum (`IDLE`, `REQ`), default `ADDR_W`/`NUM_SRC` constants, source-index constants (`SRC_PC`=0, `SRC_DBUS`=1, `SRC_IR`=2).
- Sub-module `mar_src_mux`: parametrised combinational N-to-1 selector with out-of-range detect (returns 0 plus `invalid` flag); instantiated once.

## Test plan
- Reset, then `load` src 1 = 0x5A, `mem_req_ready`=0 for 3 cycles → `mar_addr`=0x5A, valid held 3 cycles; `ready`=1 → valid low next cycle.
- `inc` in `IDLE` from 0xFF (ADDR_W=8) → `mar_addr`=0x00, no request, `mem_req_valid`=0.
- During `REQ` at 0x10, pulse `load` src 2=0x33 and `inc` without ready → `mar_addr` stays 0x10; then `load` 0x33 with ready same edge → `mar_addr`=0x33, valid stays high.
- `load` with `src_sel`=3, NUM_SRC=3 → `mar_addr`=0, `sel_err` one-cycle pulse, request opens.
- With `MAR_AUTOINC_EN`: load 0x40, accept with `auto_inc`=1 → `mar_addr`=0x41, `IDLE`; without macro → stays 0x40.
- Assert `rst_n`=0 mid-`REQ` → `mem_req_valid`, `mar_addr`, `sel_err` zero immediately, before next clock edge.
